cnn_frame_loader: RTL and testbench
===================================

// Module: cnn_frame_loader
// PURPOSE
//  Host-side driver for cnn_top. Receives a binary image as a valid/ready byte stream and packs it into the
//  flat INPUT_SIZE*INPUT_SIZE input_image vector. It then runs one cnn_top inference (start/done handshake)
//  and returns the classification result as a one-cycle pulse. Sits between the host link and cnn_top.
// PARAMETERS
//  INPUT_SIZE     64      image side in pixels; IMG_BITS = INPUT_SIZE*INPUT_SIZE (default 4096)
//  TIMEOUT_CYCLES 1000000 max cycles from start to cnn_done; must be >= 1
//  THRESHOLD      128     binarisation threshold; used only when CNN_LOADER_GRAY_EN is defined
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         asynchronous reset, active-high
//  s_data       in   8         stream byte
//  s_valid      in   1         s_data valid
//  s_ready      out  1         loader accepts a byte this cycle
//  flush        in   1         sync; discards a partial frame (LOAD only)
//  input_image  out  IMG_BITS  to cnn_top.input_image; pixel (row r, col c) is bit r*INPUT_SIZE+c
//  cnn_start    out  1         to cnn_top.start
//  cnn_done     in   1         from cnn_top.done
//  cnn_result   in   1         from cnn_top.result (1 = Diseased)
//  res_valid    out  1         one-cycle pulse: inference finished
//  res_value    out  1         captured cnn_result; valid with res_valid, held until next res_valid
//  timeout_err  out  1         one-cycle pulse: cnn_done not seen within TIMEOUT_CYCLES
//  busy         out  1         high in every state except LOAD
// BEHAVIOUR
//  Reset: state=LOAD; byte/bit counter=0; input_image=0; cnn_start=0; res_valid=0; res_value=0;
//    timeout_err=0; busy=0; s_ready=0 during reset, 1 from first clk edge after release.
//  Byte transfer: a byte moves on a rising edge with s_valid && s_ready. s_ready = (state==LOAD) && !flush.
//  Packing (macro absent): byte k goes to input_image[8k+7:8k], LSB = lower pixel index.
//    A frame is IMG_BITS/8 bytes (512 at default); IMG_BITS must be a multiple of 8.
//  Counter: after the last byte is accepted, the counter wraps to 0. input_image is never cleared between
//    frames; every bit is overwritten by the next frame.
//  States:
//   LOAD: accept bytes. Last byte of frame -> START on the next edge.
//     flush=1 -> counter=0, input_image unchanged, stay in LOAD. flush has priority over a byte in the same cycle.
//   START: cnn_start=1 (registered); timeout counter=0; -> WAIT.
//   WAIT: cnn_start held 1.
//     cnn_done=1 -> capture res_value=cnn_result, cnn_start=0, -> REPORT.
//     Else, counter reaches TIMEOUT_CYCLES-1 -> cnn_start=0, -> ERR.
//     done wins if it arrives in the same cycle as the timeout.
//   REPORT: res_valid=1 for exactly 1 cycle. -> DRAIN.
//   ERR: timeout_err=1 for exactly 1 cycle; res_value unchanged. -> DRAIN.
//   DRAIN: cnn_start=0; wait for cnn_done=0 (keeps a level-held done from retriggering) -> LOAD.
//     flush is ignored outside LOAD.
//  Latency: last byte accepted at edge N; cnn_start rises at N+1. cnn_done sampled high at edge M;
//    res_valid is high during cycle M+1..M+2.
//  The first byte of the next frame is accepted no earlier than 2 cycles after res_valid.
//  Reset mid-operation: all state is cleared asynchronously; cnn_start drops immediately.
// CONFIGURATION
//  CNN_LOADER_GRAY_EN defined:
//    Each byte is one 8-bit grayscale pixel; pixel bit = (s_data >= THRESHOLD).
//    Frame = IMG_BITS bytes (4096 at default); byte k -> input_image[k].
//  CNN_LOADER_GRAY_EN undefined:
//    Packed 8 pixels/byte as above; THRESHOLD unused.
// TESTING
//  1 Reset: assert rst mid-WAIT -> cnn_start=0 asynchronously, busy=0, s_ready=1 after release.
//  2 Packed frame, 512 bytes of 0xA5 with s_valid always high, cnn_top model done after 50 cycles
//    with result=1:
//    -> input_image = {512{8'hA5}}; cnn_start 1 cycle after byte 512; res_valid pulse; res_value=1.
//  3 Backpressure: s_valid toggling randomly -> same image as with continuous valid;
//    s_ready=0 from START until return to LOAD; no byte accepted while busy.
//  4 flush after 100 bytes, then a full 512-byte frame of 0xFF -> input_image all ones;
//    exactly one inference; no cnn_start caused by the partial frame.
//  5 Timeout: TIMEOUT_CYCLES=20, cnn_done held 0 -> timeout_err pulses 20 cycles after cnn_start rose;
//    res_valid stays 0; loader returns to LOAD.
//  6 GRAY_EN build: 4096 bytes alternating 127,128 -> input_image bits alternate 0,1
//    (bit 0 = 0, bit 1 = 1); result 0 -> res_value=0.

Source files
------------

// File: rtl/cnn_frame_loader.sv
// rtl/cnn_frame_loader.sv - byte-stream frame packer and cnn_top inference driver
//
// Purpose:
//   Collects one binary image from a valid/ready byte stream into the flat
//   input_image vector, runs one cnn_top inference through the start/done
//   handshake, and reports the result (or a timeout) as a one-cycle pulse.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   s_data/s_valid/s_ready  inbound byte stream
//   flush                 discards a partially received frame (LOAD only)
//   input_image           packed image, pixel (r,c) at bit r*INPUT_SIZE+c
//   cnn_start/cnn_done/cnn_result  handshake with cnn_top
//   res_valid/res_value   result pulse and held result value
//   timeout_err           pulse when cnn_done does not arrive in time
//   busy                  high whenever the loader is not accepting a frame
//
// Build option:
//   CNN_LOADER_GRAY_EN    one grayscale byte per pixel, binarised against
//                         THRESHOLD; otherwise 8 packed pixels per byte.

module cnn_frame_loader #(
    parameter int INPUT_SIZE     = 64,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int THRESHOLD      = 128
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         s_data,
    input  logic                               s_valid,
    output logic                               s_ready,
    input  logic                               flush,
    output logic [INPUT_SIZE*INPUT_SIZE-1:0]   input_image,
    output logic                               cnn_start,
    input  logic                               cnn_done,
    input  logic                               cnn_result,
    output logic                               res_valid,
    output logic                               res_value,
    output logic                               timeout_err,
    output logic                               busy
);

    localparam int IMG_BITS = INPUT_SIZE * INPUT_SIZE;
`ifdef CNN_LOADER_GRAY_EN
    localparam int FRAME_BYTES = IMG_BITS;
`else
    localparam int FRAME_BYTES = IMG_BITS / 8;
`endif
    localparam int CNT_W = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    if (IMG_BITS % 8 != 0) begin : g_bad_img
        $error("cnn_frame_loader: INPUT_SIZE*INPUT_SIZE must be a multiple of 8");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
        $error("cnn_frame_loader: TIMEOUT_CYCLES must be at least 1");
    end
    if (THRESHOLD < 0 || THRESHOLD > 256) begin : g_bad_thr
        $error("cnn_frame_loader: THRESHOLD must lie in 0..256");
    end

    typedef enum logic [2:0] {
        S_LOAD   = 3'd0,
        S_START  = 3'd1,
        S_WAIT   = 3'd2,
        S_REPORT = 3'd3,
        S_ERR    = 3'd4,
        S_DRAIN  = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 start_q, start_d;
    logic                 res_valid_q, res_valid_d;
    logic                 res_value_q, res_value_d;
    logic                 tmo_err_q, tmo_err_d;
    logic                 alive_q;
    logic [IMG_BITS-1:0]  input_image_q;
    logic                 accept;

    // alive_q keeps s_ready low while reset is held and until the first
    // edge after release.
    assign s_ready     = alive_q && (state_q == S_LOAD) && !flush;
    assign accept      = s_valid && s_ready;
    assign busy        = (state_q != S_LOAD);
    assign cnn_start   = start_q;
    assign res_valid   = res_valid_q;
    assign res_value   = res_value_q;
    assign timeout_err = tmo_err_q;
    assign input_image = input_image_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        tmo_d       = tmo_q;
        start_d     = start_q;
        res_valid_d = 1'b0;
        res_value_d = res_value_q;
        tmo_err_d   = 1'b0;
        case (state_q)
            S_LOAD: begin
                // flush blocks s_ready, so it always beats a same-cycle byte.
                if (flush) begin
                    cnt_d = '0;
                end else if (accept) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_START;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_START: begin
                start_d = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done is checked first so it wins over a coincident timeout.
                if (cnn_done) begin
                    res_value_d = cnn_result;
                    start_d     = 1'b0;
                    state_d     = S_REPORT;
                end else if (tmo_q == TMO_LAST) begin
                    start_d   = 1'b0;
                    tmo_err_d = 1'b1;
                    state_d   = S_ERR;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_REPORT: begin
                res_valid_d = 1'b1;
                state_d     = S_DRAIN;
            end
            S_ERR: begin
                state_d = S_DRAIN;
            end
            S_DRAIN: begin
                // A done level still held from this inference must not be
                // mistaken for the next one.
                start_d = 1'b0;
                if (!cnn_done) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                start_d = 1'b0;
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_LOAD;
            cnt_q       <= '0;
            tmo_q       <= '0;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
            res_value_q <= 1'b0;
            tmo_err_q   <= 1'b0;
            alive_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            start_q     <= start_d;
            res_valid_q <= res_valid_d;
            res_value_q <= res_value_d;
            tmo_err_q   <= tmo_err_d;
            alive_q     <= 1'b1;
        end
    end

    // Image storage is written in place; bits not addressed by the current
    // byte hold their value, so no clearing between frames is needed.
`ifdef CNN_LOADER_GRAY_EN
    logic pix_bit;
    assign pix_bit = ({1'b0, s_data} >= 9'(THRESHOLD));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            input_image_q <= '0;
        end else if (accept) begin
            input_image_q[cnt_q] <= pix_bit;
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            input_image_q <= '0;
        end else if (accept) begin
            input_image_q[{cnt_q, 3'b000} +: 8] <= s_data;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_frame_loader.sv
// tb/tb_cnn_frame_loader.sv - self-checking bench for cnn_frame_loader
module tb_cnn_frame_loader;
    localparam int INPUT_SIZE = 64;
    localparam int IMG_BITS   = INPUT_SIZE * INPUT_SIZE;
`ifdef CNN_LOADER_GRAY_EN
    localparam int FRAME_BYTES = IMG_BITS;
`else
    localparam int FRAME_BYTES = IMG_BITS / 8;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst;
    logic [7:0]          s_data;
    logic                s_valid, s_ready, flush;
    logic [IMG_BITS-1:0] input_image;
    logic                cnn_start, cnn_done, cnn_result;
    logic                res_valid, res_value, timeout_err, busy;

    logic [7:0]          t_s_data;
    logic                t_s_valid, t_s_ready, t_flush;
    logic [IMG_BITS-1:0] t_input_image;
    logic                t_cnn_start, t_cnn_done, t_cnn_result;
    logic                t_res_valid, t_res_value, t_timeout_err, t_busy;

    cnn_frame_loader #(.INPUT_SIZE(INPUT_SIZE), .TIMEOUT_CYCLES(200), .THRESHOLD(128)) u_dut (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .flush(flush), .input_image(input_image), .cnn_start(cnn_start), .cnn_done(cnn_done),
        .cnn_result(cnn_result), .res_valid(res_valid), .res_value(res_value),
        .timeout_err(timeout_err), .busy(busy)
    );

    cnn_frame_loader #(.INPUT_SIZE(INPUT_SIZE), .TIMEOUT_CYCLES(20), .THRESHOLD(128)) u_tmo (
        .clk(clk), .rst(rst), .s_data(t_s_data), .s_valid(t_s_valid), .s_ready(t_s_ready),
        .flush(t_flush), .input_image(t_input_image), .cnn_start(t_cnn_start),
        .cnn_done(t_cnn_done), .cnn_result(t_cnn_result), .res_valid(t_res_valid),
        .res_value(t_res_value), .timeout_err(t_timeout_err), .busy(t_busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [IMG_BITS-1:0] exp_img;

    int   starts = 0;
    int   leak   = 0;
    logic st_prev = 1'b0;
    always @(negedge clk) begin
        st_prev <= cnn_start;
        if (cnn_start && !st_prev) starts <= starts + 1;
        if (busy && s_ready) leak <= leak + 1;
    end

    function automatic logic [7:0] pat(input int id, input int k);
        case (id)
            0:       return 8'hA5;
            1:       return 8'(k) ^ 8'h3C;
            2:       return 8'hFF;
            3:       return 8'h00;
            default: return (k % 2 == 1) ? 8'd128 : 8'd127;
        endcase
    endfunction

    // Feeds n bytes of pattern id to u_dut; returns at the negedge after the
    // edge that accepted the last byte, with s_valid dropped.
    task automatic send_bytes(input int id, input int n, input bit rnd, output bit ok);
        int acc = 0;
        int cyc = 0;
        logic [7:0] b;
        bit v;
        ok = 1'b1;
        while (acc < n) begin
            @(negedge clk);
            cyc++;
            if (cyc > n * 4 + 64) begin
                ok = 1'b0;
                break;
            end
            b = pat(id, acc);
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data = b;
            s_valid = v;
            #1;
            if (v && s_ready) begin
`ifdef CNN_LOADER_GRAY_EN
                exp_img[acc] = (b >= 8'd128);
`else
                exp_img[acc*8 +: 8] = b;
`endif
                acc++;
            end
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Plays cnn_top: waits for start, raises done after lat cycles, releases it
    // once res_valid was seen, then waits for the loader to return to LOAD.
    task automatic do_infer(input int lat, input bit r, output bit ok);
        int t = 0;
        bit rv;
        ok = 1'b1;
        while (!cnn_start && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (!cnn_start) ok = 1'b0;
        repeat (lat) @(negedge clk);
        cnn_done = 1'b1;
        cnn_result = r;
        @(negedge clk);
        @(negedge clk);
        rv = res_valid;
        cnn_done = 1'b0;
        t = 0;
        while (busy && t < 8) begin
            @(negedge clk);
            t++;
        end
        if (!rv || busy) ok = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_checks++; if (cnn_start !== 1'b0) begin n_fail++; $display("FAIL rst_cnn_start: got %b want 0", cnn_start); end
        n_checks++; if ({res_valid, res_value, timeout_err} !== 3'b000) begin n_fail++; $display("FAIL rst_outputs: got %b want 000", {res_valid, res_value, timeout_err}); end
        n_checks++; if (input_image !== '0) begin n_fail++; $display("FAIL rst_image: got low word %h want 0", input_image[31:0]); end
        rst = 1'b0;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL rst_release_ready: got %b want 0 before first edge", s_ready); end
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_after: got %b want 1", s_ready); end
        send_bytes(0, FRAME_BYTES, 1'b0, ok);
        @(negedge clk);
        @(negedge clk);
        n_checks++; if (cnn_start !== 1'b1) begin n_fail++; $display("FAIL rst_wait_start: got %b want 1", cnn_start); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (cnn_start !== 1'b0) begin n_fail++; $display("FAIL rst_async_start: got %b want 0", cnn_start); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy: got %b want 0", busy); end
        n_checks++; if (input_image !== '0) begin n_fail++; $display("FAIL rst_async_image: got low word %h want 0", input_image[31:0]); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (s_ready !== 1'b1) begin n_fail++; $display("FAIL rst_mid_ready: got %b want 1", s_ready); end
    endtask

    task automatic test_packed();
        bit ok;
        logic [IMG_BITS-1:0] want;
`ifdef CNN_LOADER_GRAY_EN
        want = '1;
`else
        want = {FRAME_BYTES{8'hA5}};
`endif
        send_bytes(0, FRAME_BYTES, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL packed_load: got stalled want all bytes accepted"); end
        n_checks++; if ({cnn_start, busy, s_ready} !== 3'b010) begin n_fail++; $display("FAIL packed_start_state: got %b want 010", {cnn_start, busy, s_ready}); end
        @(negedge clk);
        n_checks++; if (cnn_start !== 1'b1) begin n_fail++; $display("FAIL packed_start_latency: got %b want 1", cnn_start); end
        repeat (49) @(negedge clk);
        n_checks++; if (cnn_start !== 1'b1) begin n_fail++; $display("FAIL packed_start_held: got %b want 1", cnn_start); end
        cnn_done = 1'b1;
        cnn_result = 1'b1;
        @(negedge clk);
        n_checks++; if ({cnn_start, res_valid} !== 2'b00) begin n_fail++; $display("FAIL packed_after_done: got %b want 00", {cnn_start, res_valid}); end
        @(negedge clk);
        n_checks++; if ({res_valid, res_value} !== 2'b11) begin n_fail++; $display("FAIL packed_result: got %b want 11", {res_valid, res_value}); end
        @(negedge clk);
        n_checks++; if ({res_valid, busy, s_ready} !== 3'b010) begin n_fail++; $display("FAIL packed_drain: got %b want 010", {res_valid, busy, s_ready}); end
        cnn_done = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy, s_ready} !== 2'b01) begin n_fail++; $display("FAIL packed_back_to_load: got %b want 01", {busy, s_ready}); end
        n_checks++; if (input_image !== want) begin n_fail++; $display("FAIL packed_image: got low word %h want %h", input_image[31:0], want[31:0]); end
    endtask

    task automatic test_backpressure();
        bit ok;
        send_bytes(1, FRAME_BYTES, 1'b1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_load: got stalled want all bytes accepted"); end
        s_data = 8'h00;
        s_valid = 1'b1;
        do_infer(5, 1'b0, ok);
        s_valid = 1'b0;
        n_checks++; if (!ok) begin n_fail++; $display("FAIL bp_infer: got no clean handshake want start/res_valid/return"); end
        n_checks++; if (leak !== 0) begin n_fail++; $display("FAIL bp_ready_while_busy: got %0d cycles want 0", leak); end
        n_checks++; if (res_value !== 1'b0) begin n_fail++; $display("FAIL bp_res_value: got %b want 0", res_value); end
        n_checks++; if (input_image !== exp_img) begin n_fail++; $display("FAIL bp_image: got low word %h want %h", input_image[31:0], exp_img[31:0]); end
    endtask

    task automatic test_flush();
        bit ok;
        int s0;
        s0 = starts;
        send_bytes(3, 100, 1'b0, ok);
        flush = 1'b1;
        s_valid = 1'b1;
        s_data = 8'hFF;
        #1;
        n_checks++; if (s_ready !== 1'b0) begin n_fail++; $display("FAIL flush_ready: got %b want 0", s_ready); end
        @(negedge clk);
        flush = 1'b0;
        s_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (busy !== 1'b0 || starts !== s0) begin n_fail++; $display("FAIL flush_no_start: got busy %b starts %0d want 0 %0d", busy, starts, s0); end
        send_bytes(2, FRAME_BYTES, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_load: got stalled want all bytes accepted"); end
        do_infer(7, 1'b1, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL flush_infer: got no clean handshake want start/res_valid/return"); end
        n_checks++; if (starts !== s0 + 1) begin n_fail++; $display("FAIL flush_one_inference: got %0d want %0d", starts, s0 + 1); end
        n_checks++; if (input_image !== {IMG_BITS{1'b1}}) begin n_fail++; $display("FAIL flush_image: got low word %h want ffffffff", input_image[31:0]); end
        n_checks++; if (res_value !== 1'b1) begin n_fail++; $display("FAIL flush_res_value: got %b want 1", res_value); end
    endtask

    task automatic test_timeout();
        int k = 0;
        int nready = 0;
        bit rv = 1'b0;
        for (int i = 0; i < FRAME_BYTES; i++) begin
            @(negedge clk);
            t_s_data = 8'h5A;
            t_s_valid = 1'b1;
            #1;
            if (!t_s_ready) nready++;
        end
        @(negedge clk);
        t_s_valid = 1'b0;
        n_checks++; if (nready !== 0) begin n_fail++; $display("FAIL tmo_load_ready: got %0d stalls want 0", nready); end
        @(negedge clk);
        n_checks++; if (t_cnn_start !== 1'b1) begin n_fail++; $display("FAIL tmo_start: got %b want 1", t_cnn_start); end
        while (!t_timeout_err && k < 40) begin
            @(negedge clk);
            k++;
            if (t_res_valid) rv = 1'b1;
        end
        n_checks++; if (k !== 20) begin n_fail++; $display("FAIL tmo_latency: got %0d cycles want 20", k); end
        n_checks++; if (t_cnn_start !== 1'b0) begin n_fail++; $display("FAIL tmo_start_drop: got %b want 0", t_cnn_start); end
        @(negedge clk);
        if (t_res_valid) rv = 1'b1;
        n_checks++; if (t_timeout_err !== 1'b0) begin n_fail++; $display("FAIL tmo_pulse_width: got %b want 0", t_timeout_err); end
        @(negedge clk);
        n_checks++; if ({t_busy, t_s_ready} !== 2'b01) begin n_fail++; $display("FAIL tmo_back_to_load: got %b want 01", {t_busy, t_s_ready}); end
        n_checks++; if (rv !== 1'b0 || t_res_value !== 1'b0) begin n_fail++; $display("FAIL tmo_no_result: got res_valid seen %b value %b want 0 0", rv, t_res_value); end
    endtask

`ifdef CNN_LOADER_GRAY_EN
    task automatic test_gray();
        bit ok;
        send_bytes(4, FRAME_BYTES, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gray_load: got stalled want all bytes accepted"); end
        do_infer(10, 1'b0, ok);
        n_checks++; if (!ok) begin n_fail++; $display("FAIL gray_infer: got no clean handshake want start/res_valid/return"); end
        n_checks++; if (input_image[1:0] !== 2'b10) begin n_fail++; $display("FAIL gray_bits01: got %b want 10", input_image[1:0]); end
        n_checks++; if (input_image !== {(IMG_BITS/2){2'b10}}) begin n_fail++; $display("FAIL gray_image: got low word %h want aaaaaaaa", input_image[31:0]); end
        n_checks++; if (res_value !== 1'b0) begin n_fail++; $display("FAIL gray_res_value: got %b want 0", res_value); end
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_data = 8'h00; s_valid = 1'b0; flush = 1'b0;
        cnn_done = 1'b0; cnn_result = 1'b0;
        t_s_data = 8'h00; t_s_valid = 1'b0; t_flush = 1'b0;
        t_cnn_done = 1'b0; t_cnn_result = 1'b0;
        exp_img = '0;
        test_reset();
        test_packed();
        test_backpressure();
        test_flush();
        test_timeout();
`ifdef CNN_LOADER_GRAY_EN
        test_gray();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
